// File: rtl/rib_mem_responder.sv
// Word-addressed RIB slave memory with fixed wait-state latency.
// One transaction at a time: accept, wait, then a single-cycle ack.
module rib_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        hold_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_we;

  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic        cur_we;
  logic [29:0] idx;
  logic [AW-1:0] widx;
  logic        in_range;
  logic        commit;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accepting edge,
  // so the live bus values stand in for the not-yet-latched ones.
  always_comb begin
    cur_addr = lat_addr;
    cur_data = lat_data;
    cur_we   = lat_we;
    if (state == IDLE) begin
      cur_addr = addr_i;
      cur_data = data_i;
      cur_we   = we_i;
    end
  end

  assign idx      = 30'((cur_addr - BASE_ADDR) >> 2);
  assign widx     = idx[AW-1:0];
  assign in_range = (cur_addr >= BASE_ADDR)
                 && ({2'b00, idx} < 32'(DEPTH_WORDS));

  assign commit = !rst && (
      (state == IDLE && req_i && WAIT_CYCLES == 0)
   || (state == WAIT && cnt == 4'd0));

  assign hold_o = (state != IDLE) || req_i;

  always_ff @(posedge clk) begin
    if (commit && cur_we && in_range)
      mem[widx] <= cur_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            lat_addr <= addr_i;
            lat_data <= data_i;
            lat_we   <= we_i;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACK;
          else             cnt   <= cnt - 4'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        ack_o  <= 1'b1;
        err_o  <= !in_range;
        data_o <= (in_range && !cur_we) ? mem[widx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rib_mem_responder.sv
// Bench for rib_mem_responder: three instances (0, 1, 3 wait states)
// share one bus; a per-instance reference memory feeds a scoreboard.
module tb_rib_mem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] dout [3];
  logic [2:0]  ack, err, hold;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rib_mem_responder #(
      .BASE_ADDR(BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) dut (
      .clk(clk),
      .rst(rst),
      .req_i(req),
      .we_i(we),
      .addr_i(addr),
      .data_i(wdata),
      .data_o(dout[g]),
      .ack_o(ack[g]),
      .err_o(err[g]),
      .hold_o(hold[g])
    );
  end

  typedef struct {
    int          due;
    bit          we;
    bit          err;
    bit          known;
    logic [31:0] data;
  } exp_t;

  exp_t        sq [3][$];
  logic [31:0] mdl [bit [31:0]];
  int          busy [3];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;

  function automatic int wv(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %h expected %h",
               name, k, cyc, got, exp);
    end
  endtask

  // Monitor: pops an expectation whenever its ack cycle arrives.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        bit   ea;
        exp_t e;
        ea = (sq[k].size() > 0) && (sq[k][0].due == cyc);
        chk("hold", k, {31'b0, hold[k]}, {31'b0, req || (cyc <= busy[k])});
        chk("ack", k, {31'b0, ack[k]}, {31'b0, ea});
        if (ea) begin
          e = sq[k].pop_front();
          chk("err", k, {31'b0, err[k]}, {31'b0, e.err});
          if (!e.we && e.known) chk("rdata", k, dout[k], e.data);
        end else begin
          chk("err_idle", k, {31'b0, err[k]}, 32'd0);
          chk("data_idle", k, dout[k], 32'd0);
        end
      end
    end
  end

  // Reference: what each instance should do for one accepted access.
  task automatic model(int k, int t, bit w, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    bit          inr;
    logic [31:0] off;
    bit   [31:0] key;
    off = a - BASE;
    inr = (a >= BASE) && ((off / 4) < DEPTH);
    key = {k[1:0], off[31:2]};
    e.due   = t + 1 + wv(k);
    e.we    = w;
    e.err   = !inr;
    e.known = 1'b1;
    e.data  = '0;
    if (w) begin
      if (inr) mdl[key] = d;
    end else if (inr) begin
      e.known = mdl.exists(key);
      e.data  = e.known ? mdl[key] : '0;
    end
    sq[k].push_back(e);
    busy[k] = e.due;
  endtask

  // Holds req for len cycles; roff>0 pulses rst roff cycles after accept.
  task automatic issue(bit w, logic [31:0] a, logic [31:0] d,
                       int len, int roff);
    int n;
    @(posedge clk); #1;
    n = cyc;
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 0; k < 3; k++) begin
      if (roff > 0 && roff <= wv(k)) begin
        busy[k] = n + roff;
      end else begin
        for (int t = n; t <= n + len - 1; t += wv(k) + 2)
          model(k, t, w, a, d);
      end
    end
    repeat (len) begin
      @(posedge clk); #1;
    end
    req = 1'b0;
    we = $urandom_range(0, 1);
    addr = $urandom;
    wdata = $urandom;
    if (roff > 0) begin
      repeat (roff - 1) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    repeat (6) @(posedge clk);
  endtask

  logic [31:0] pool [8];
  logic [31:0] oor  [4];

  initial begin
    for (int k = 0; k < 3; k++) busy[k] = -1;
    pool[0] = BASE;
    pool[1] = BASE + 32'h10;
    pool[2] = BASE + 32'h14;
    pool[3] = BASE + 32'h400;
    pool[4] = BASE + 32'h3FF8;
    pool[5] = BASE + 32'h3FFC;
    pool[6] = BASE + 32'h0800;
    pool[7] = BASE + 32'h1234;
    oor[0] = 32'h0FFF_FFFC;
    oor[1] = 32'h1000_4000;
    oor[2] = 32'hFFFF_FFFC;
    oor[3] = 32'h0000_0000;

    @(posedge clk); #1;
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) issue(1'b1, pool[i], $urandom, 1, 0);

    issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 1, 0);
    issue(1'b0, 32'h1000_0010, 32'h0, 1, 0);
    issue(1'b1, 32'h1000_0010, 32'h1234_5678, 1, 0);
    issue(1'b0, 32'h1000_0013, 32'h0, 1, 0);
    issue(1'b0, 32'h0FFF_FFFC, 32'h0, 1, 0);
    issue(1'b0, 32'h1000_4000, 32'h0, 1, 0);
    issue(1'b1, 32'h1000_4000, 32'h5555_AAAA, 1, 0);
    issue(1'b0, 32'h1000_0000, 32'h0, 1, 0);
    issue(1'b0, 32'h1000_3FFC, 32'h0, 1, 0);
    issue(1'b1, 32'h1000_0020, 32'h0BAD_F00D, 1, 0);
    issue(1'b1, 32'h1000_0020, 32'hA5A5_A5A5, 1, 2);
    issue(1'b0, 32'h1000_0020, 32'h0, 1, 0);
    issue(1'b0, 32'h1000_0010, 32'h0, 9, 0);
    issue(1'b1, 32'h1000_0400, 32'h1, 1, 0);
    issue(1'b1, 32'h1000_0400, 32'h2, 1, 0);
    issue(1'b0, 32'h1000_0400, 32'h0, 1, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0)
        a = oor[$urandom_range(0, 3)];
      else
        a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      issue($urandom_range(0, 1) == 1, a, $urandom,
            ($urandom_range(0, 4) == 0) ? $urandom_range(2, 5) : 1,
            ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end

    repeat (8) @(posedge clk);
    for (int k = 0; k < 3; k++)
      chk("leftover", k, sq[k].size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
